// File: rtl/ped_xing_ctrl.sv
// Request-driven pedestrian crossing sequencer: RED -> GREEN -> ORANGE.
// Phase lengths are in prescaled ticks; all lamp outputs are registered.
module ped_xing_ctrl #(
  parameter int CLK_PER_TICK = 4,
  parameter int T_RED_MIN    = 4,
  parameter int T_GREEN      = 6,
  parameter int T_ORANGE     = 3,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       green_walk,
  output logic       orange_walk,
  output logic       red_hand,
  output logic       req_pending,
  output logic [1:0] phase
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  localparam logic [PW-1:0]    PRE_MAX = PW'(CLK_PER_TICK - 1);
  localparam logic [CNT_W-1:0] RED_LST = CNT_W'(T_RED_MIN - 1);
  localparam logic [CNT_W-1:0] GRN_LST = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] ORG_LST = CNT_W'(T_ORANGE - 1);

  localparam logic [1:0] S_RED    = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_ORANGE = 2'd2;

  logic [1:0]       r_phase;
  logic [PW-1:0]    r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic             r_min;
  logic             r_pend;
  logic             r_green;
  logic             r_orange;
  logic             r_red;

  logic             w_tick;
  logic             w_last;
  logic             w_restart;
  logic             w_enter_green;
  logic [1:0]       w_phase_nxt;
  logic [PW-1:0]    w_pre_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_min_nxt;
  logic             w_pend_nxt;

  always_comb begin
    w_tick      = (r_pre == PRE_MAX);
    w_last      = 1'b0;
    w_restart   = 1'b0;
    w_phase_nxt = r_phase;
    w_min_nxt   = r_min;
    unique case (r_phase)
      S_RED: begin
        w_last = w_tick && (r_cnt == RED_LST);
        // Once the minimum is served the counters park at zero
        if (r_min) begin
          w_restart = 1'b1;
          if (r_pend) w_phase_nxt = S_GREEN;
        end else if (w_last) begin
          w_restart = 1'b1;
          if (r_pend) w_phase_nxt = S_GREEN;
          else        w_min_nxt   = 1'b1;
        end
      end
      S_GREEN: begin
        w_last = w_tick && (r_cnt == GRN_LST);
        if (w_last) begin
          w_restart   = 1'b1;
          w_phase_nxt = S_ORANGE;
        end
      end
      S_ORANGE: begin
        w_last = w_tick && (r_cnt == ORG_LST);
        if (w_last) begin
          w_restart   = 1'b1;
          w_phase_nxt = S_RED;
          w_min_nxt   = 1'b0;
        end
      end
      default: begin
        w_restart   = 1'b1;
        w_phase_nxt = S_RED;
        w_min_nxt   = 1'b0;
      end
    endcase

    if (w_restart || w_tick) w_pre_nxt = '0;
    else                     w_pre_nxt = r_pre + PW'(1);

    if (w_restart)   w_cnt_nxt = '0;
    else if (w_tick) w_cnt_nxt = r_cnt + CNT_W'(1);
    else             w_cnt_nxt = r_cnt;

    w_enter_green = (r_phase != S_GREEN) && (w_phase_nxt == S_GREEN);

    if (w_enter_green)                 w_pend_nxt = 1'b0;
    else if (req && r_phase != S_GREEN) w_pend_nxt = 1'b1;
    else                               w_pend_nxt = r_pend;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase  <= S_RED;
      r_pre    <= '0;
      r_cnt    <= '0;
      r_min    <= 1'b0;
      r_pend   <= 1'b0;
      r_green  <= 1'b0;
      r_orange <= 1'b0;
      r_red    <= 1'b1;
    end else begin
      r_phase  <= w_phase_nxt;
      r_pre    <= w_pre_nxt;
      r_cnt    <= w_cnt_nxt;
      r_min    <= w_min_nxt;
      r_pend   <= w_pend_nxt;
      r_green  <= (w_phase_nxt == S_GREEN);
      r_red    <= (w_phase_nxt == S_RED);
      r_orange <= (w_phase_nxt == S_ORANGE) && !w_cnt_nxt[0];
    end
  end

  assign phase       = r_phase;
  assign green_walk  = r_green;
  assign orange_walk = r_orange;
  assign red_hand    = r_red;
  assign req_pending = r_pend;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Directed bench for ped_xing_ctrl: default timing plus a
// minimum-parameter instance.
module tb_ped_xing_ctrl;

  logic       clk = 1'b0;
  logic       reset, req;
  logic       gw, ow, rh, rp;
  logic [1:0] ph;
  logic       reset2, req2;
  logic       gw2, ow2, rh2, rp2;
  logic [1:0] ph2;

  int ntest = 0;
  int nfail = 0;
  int exp_ph;
  bit exp_o, exp_p;

  always #5 clk = ~clk;

  ped_xing_ctrl dut (
    .clk(clk), .reset(reset), .req(req),
    .green_walk(gw), .orange_walk(ow), .red_hand(rh),
    .req_pending(rp), .phase(ph)
  );

  ped_xing_ctrl #(
    .CLK_PER_TICK(1), .T_RED_MIN(1), .T_GREEN(1), .T_ORANGE(1)
  ) dut2 (
    .clk(clk), .reset(reset2), .req(req2),
    .green_walk(gw2), .orange_walk(ow2), .red_hand(rh2),
    .req_pending(rp2), .phase(ph2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c,
                     input logic [5:0] obs, input logic [5:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d obs=%b exp=%b", tag, c, obs, exp);
    end
  endtask

  function automatic logic [5:0] mk(input int p, input bit o, input bit q);
    logic [1:0] pp;
    pp = p[1:0];
    return {pp, p == 0, p == 1, o, q};
  endfunction

  function automatic bit orng(input int c, input int s);
    return ((c - s) / 4) % 2 == 0;
  endfunction

  function automatic int std_ph(input int c, input int g);
    if (c < g)      return 0;
    if (c < g + 24) return 1;
    if (c < g + 36) return 2;
    return 0;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    req   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [5:0] obs1;
    return {ph, rh, gw, ow, rp};
  endfunction

  initial begin
    reset  = 1'b1;
    req    = 1'b0;
    reset2 = 1'b1;
    req2   = 1'b0;

    // A: idle after reset
    do_reset();
    for (int c = 0; c < 200; c++) begin
      chk("idle", c, obs1(), mk(0, 0, 0));
      tick();
    end

    // B: request at cycle 0
    do_reset();
    for (int c = 0; c < 60; c++) begin
      req   = (c == 0);
      exp_ph = std_ph(c, 16);
      exp_o  = (exp_ph == 2) && orng(c, 40);
      exp_p  = (c >= 1 && c < 16);
      chk("req0", c, obs1(), mk(exp_ph, exp_o, exp_p));
      tick();
    end

    // C: late single-cycle request
    do_reset();
    for (int c = 0; c < 75; c++) begin
      req   = (c == 30);
      exp_ph = std_ph(c, 32);
      exp_o  = (exp_ph == 2) && orng(c, 56);
      exp_p  = (c == 31);
      chk("late", c, obs1(), mk(exp_ph, exp_o, exp_p));
      tick();
    end

    // D: request during GREEN is ignored
    do_reset();
    for (int c = 0; c < 120; c++) begin
      req   = (c == 0) || (c == 20);
      exp_ph = std_ph(c, 16);
      exp_o  = (exp_ph == 2) && orng(c, 40);
      exp_p  = (c >= 1 && c < 16);
      chk("grn_ign", c, obs1(), mk(exp_ph, exp_o, exp_p));
      tick();
    end

    // E: request in final ORANGE cycle
    do_reset();
    for (int c = 0; c < 110; c++) begin
      req = (c == 0) || (c == 51);
      if (c < 52) exp_ph = std_ph(c, 16);
      else        exp_ph = std_ph(c, 68);
      if (c < 52) exp_o = (exp_ph == 2) && orng(c, 40);
      else        exp_o = (exp_ph == 2) && orng(c, 92);
      exp_p = (c >= 1 && c < 16) || (c >= 52 && c < 68);
      chk("org_last", c, obs1(), mk(exp_ph, exp_o, exp_p));
      tick();
    end

    // F: reset pulse in ORANGE
    do_reset();
    for (int c = 0; c < 95; c++) begin
      reset = (c == 45);
      req   = (c == 0) || (c == 45) || (c == 46);
      if (c < 16)      exp_ph = 0;
      else if (c < 40) exp_ph = 1;
      else if (c < 46) exp_ph = 2;
      else if (c < 62) exp_ph = 0;
      else if (c < 86) exp_ph = 1;
      else             exp_ph = 2;
      if (c < 46) exp_o = (exp_ph == 2) && orng(c, 40);
      else        exp_o = (exp_ph == 2) && orng(c, 86);
      exp_p = (c >= 1 && c < 16) || (c >= 47 && c < 62);
      chk("mid_rst", c, obs1(), mk(exp_ph, exp_o, exp_p));
      tick();
    end
    reset = 1'b0;
    req   = 1'b0;

    // G: minimum parameters, request held
    reset2 = 1'b1;
    req2   = 1'b0;
    tick();
    tick();
    reset2 = 1'b0;
    req2   = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c < 2)                exp_ph = 0;
      else if ((c - 2) % 3 == 0) exp_ph = 1;
      else if ((c - 2) % 3 == 1) exp_ph = 2;
      else                      exp_ph = 0;
      exp_o = (exp_ph == 2);
      chk("min_par", c, {ph2, rh2, gw2, ow2, 1'b0},
          mk(exp_ph, exp_o, 1'b0));
      if (c == 1)
        chk("min_pend", c, {5'd0, rp2}, 6'd1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/ped_xing_ctrl.md
# ped_xing_ctrl

Parametrised, request-driven successor to the fixed-cycle crosswalk control unit. It sequences one pedestrian crossing through RED → GREEN → ORANGE. Phase lengths are programmable in ticks, and ticks come from an internal prescaler. Red has a minimum dwell and is left only after a pedestrian request has been latched. Orange flashes at tick rate. The block sits directly under the crossing top level and drives the lamp outputs.

## Interface
- `CLK_PER_TICK`, default 4: clock cycles per tick, ≥1.
- `T_RED_MIN`, default 4: minimum RED dwell in ticks, ≥1.
- `T_GREEN`, default 6: GREEN duration in ticks, ≥1.
- `T_ORANGE`, default 3: ORANGE duration in ticks, ≥1.
- `CNT_W`, default 8: tick-counter width. Must satisfy 2^CNT_W > max(T_RED_MIN, T_GREEN, T_ORANGE).
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: pedestrian button, level, sampled every cycle.
- `green_walk` output 1: walk lamp.
- `orange_walk` output 1: flashing clearance lamp.
- `red_hand` output 1: don't-walk lamp.
- `req_pending` output 1: latched request.
- `phase` output 2: 0 = RED, 1 = GREEN, 2 = ORANGE. Encoding 3 is never produced.

## Operation
- **Reset values:** `phase`=0 (RED), `red_hand`=1, `green_walk`=0, `orange_walk`=0, `req_pending`=0. Prescaler, tick counter and the min-elapsed flag are 0. `req` is ignored while `reset`=1. Reset asserted mid-phase aborts the phase and returns to the reset values on the next edge.
- **Prescaler:** counts 0..CLK_PER_TICK-1. A tick is the cycle where prescaler = CLK_PER_TICK-1. The prescaler wraps to 0 after the tick.
- **Tick counter:** CNT_W bits, incremented on each tick.
- **Restart on transition:** prescaler and tick counter both restart at 0 on every phase transition, so every phase starts on a tick boundary.
- **Phase end:** a phase's last cycle is the tick cycle where tick counter = T-1. T is the phase's tick length.
- **RED:**
  - Counts toward T_RED_MIN.
  - At the last cycle of the minimum: if `req_pending`=1, go to GREEN at that edge. Otherwise set min-elapsed and hold RED; counters stop.
  - With min-elapsed=1: go to GREEN at the end of the first cycle with `req_pending`=1.
- **GREEN:** lasts exactly T_GREEN·CLK_PER_TICK cycles, then ORANGE.
- **ORANGE:**
  - Lasts exactly T_ORANGE·CLK_PER_TICK cycles, then RED. Min-elapsed is cleared on entry to RED.
  - `orange_walk` equals the inverse of tick-counter bit 0: 1 on even ticks, 0 on odd ticks.
- **Request latch:**
  - `req`=1 in a RED or ORANGE cycle sets `req_pending` at that edge.
  - `req` in a GREEN cycle is ignored.
  - `req_pending` clears on the edge entering GREEN, so it reads 0 in the first GREEN cycle.
  - `req` in the final ORANGE cycle is latched.
- **Lamp invariants:**
  - `green_walk` and `red_hand` are mutually exclusive, and exactly one of them is 1 outside ORANGE.
  - In ORANGE both are 0.
  - All outputs are registered.

## Timing
- Cycle 0 is the first cycle with `reset`=0. Defaults apply: RED min = 16 cycles, GREEN = 24, ORANGE = 12.
- **req asserted at cycle 0:**
  - `req_pending` reads 1 at cycle 1.
  - RED covers cycles 0–15, GREEN 16–39, ORANGE 40–51, and RED resumes at 52.
- **Orange pattern:** `orange_walk`=1 on cycles 40–43, 0 on 44–47, 1 on 48–51.
- **Request after minimum:** request arrives after the minimum has elapsed (`req` high only at cycle k ≥ 16) → `req_pending`=1 at k+1, GREEN from k+2. Latency from `req` to `green_walk` is 2 cycles.
- **Request at the RED boundary:** `req` at cycle 14 → pending at 15 → GREEN at 16. `req` at cycle 15 → pending at 16 → GREEN at 17.
- **Minimum parameters:** with CLK_PER_TICK=1 and all T=1, the block still holds each phase exactly one cycle.

## Test plan
- **Reset then idle:** `req`=0 for 200 cycles → `red_hand`=1, `phase`=0, other outputs 0 throughout.
- **Request from cycle 0 (defaults):** `req`=1 at cycle 0 → GREEN 16–39, ORANGE 40–51 with the 1/0/1 four-cycle flash, RED at 52, `req_pending` 0 at 16.
- **Late single-cycle request:** one-cycle `req` at cycle 30 → `req_pending` 1 at 31, `green_walk` 1 at 32 for exactly 24 cycles.
- **Latch qualification:**
  - `req` pulsed during GREEN → no new cycle after ORANGE; RED holds.
  - `req` pulsed in the last ORANGE cycle → GREEN begins exactly 16 cycles into the next RED.
- **Reset mid-operation:** reset asserted in cycle 45 (ORANGE) for one cycle → next cycle shows `red_hand`=1, `req_pending`=0, and the full 16-cycle RED minimum re-applies.
- **Parameter sweep:** CLK_PER_TICK=1, T_RED_MIN=1, T_GREEN=1, T_ORANGE=1 with `req` held → `phase` repeats 0,1,2 each cycle, `orange_walk`=1 in every ORANGE cycle, never two lamps high simultaneously.
